// File: rtl/periph_bus_bridge_pkg.sv
// Shared bus widths, access-size codes, bridge defaults and slave indices
// for the peripheral bus bridge.
package periph_bus_bridge_pkg;

  localparam int unsigned BUS_WIDTH     = 32;
  localparam int unsigned BUS_ACC_WIDTH = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  localparam int unsigned PBB_N_SLV    = 4;
  localparam int unsigned PBB_SEL_LSB  = 8;
  localparam int unsigned PBB_SEL_W    = 4;
  localparam int unsigned PBB_VA_WIDTH = 8;
  localparam int unsigned PBB_TIMEOUT  = 15;

  localparam int unsigned PBB_SLV_TMR  = 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } pbb_state_e;

endpackage

// File: rtl/pbb_addr_decode.sv
// Combinational decode of a master byte address into a slave select and
// a decode-error flag (bad select, nonzero gap bits or nonzero high bits).
module pbb_addr_decode
  import periph_bus_bridge_pkg::*;
#(
  parameter int unsigned N_SLV    = PBB_N_SLV,
  parameter int unsigned SEL_LSB  = PBB_SEL_LSB,
  parameter int unsigned SEL_W    = PBB_SEL_W,
  parameter int unsigned VA_WIDTH = PBB_VA_WIDTH
) (
  input  logic [31:0]      addr_i,
  output logic [SEL_W-1:0] dsel_o,
  output logic             dec_err_o
);

  always_comb begin
    dsel_o    = addr_i[SEL_LSB +: SEL_W];
    dec_err_o = ({{(32-SEL_W){1'b0}}, dsel_o} >= N_SLV);
    // Bits between the local window and the select field, and above the select
    // field, must all be zero; the loop form also covers an empty gap.
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i >= VA_WIDTH && i < SEL_LSB) || (i >= SEL_LSB + SEL_W)) begin
        dec_err_o = dec_err_o | addr_i[i];
      end
    end
  end

endmodule

// File: rtl/periph_bus_bridge.sv
// Single-master to N-slave peripheral bridge: zero-latency request forwarding,
// one outstanding access, decode/slave/protocol faults and a response timeout.
module periph_bus_bridge
  import periph_bus_bridge_pkg::*;
#(
  parameter int unsigned N_SLV    = PBB_N_SLV,
  parameter int unsigned SEL_LSB  = PBB_SEL_LSB,
  parameter int unsigned SEL_W    = PBB_SEL_W,
  parameter int unsigned VA_WIDTH = PBB_VA_WIDTH,
  parameter int unsigned TIMEOUT  = PBB_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [31:0]                  m_addr,
  input  logic                         m_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0]     m_acc,
  input  logic [BUS_WIDTH-1:0]         m_wdata,
  input  logic                         m_req,
  output logic [BUS_WIDTH-1:0]         m_rdata,
  output logic                         m_resp,
  output logic                         m_fault,
  output logic [VA_WIDTH-1:0]          s_addr,
  output logic                         s_w_rb,
  output logic [BUS_ACC_WIDTH-1:0]     s_acc,
  output logic [BUS_WIDTH-1:0]         s_wdata,
  output logic [N_SLV-1:0]             s_req,
  input  logic [N_SLV*BUS_WIDTH-1:0]   s_rdata,
  input  logic [N_SLV-1:0]             s_resp,
  input  logic [N_SLV-1:0]             s_fault,
  output logic                         to_flag
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  pbb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_flag_q, to_flag_d;

  logic [SEL_W-1:0]     dsel;
  logic                 dec_err;
  logic                 resp_sel, dfault, accept, fault, in_wait;
  logic [BUS_WIDTH-1:0] rdata_sel;
  logic [N_SLV-1:0]     req_d;

  pbb_addr_decode #(
    .N_SLV   (N_SLV),
    .SEL_LSB (SEL_LSB),
    .SEL_W   (SEL_W),
    .VA_WIDTH(VA_WIDTH)
  ) u_dec (
    .addr_i   (m_addr),
    .dsel_o   (dsel),
    .dec_err_o(dec_err)
  );

  assign s_addr  = m_addr[VA_WIDTH-1:0];
  assign s_w_rb  = m_w_rb;
  assign s_acc   = m_acc;
  assign s_wdata = m_wdata;

  always_comb begin
    resp_sel  = 1'b0;
    rdata_sel = '0;
    dfault    = 1'b0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (sel_q == SEL_W'(i)) begin
        resp_sel  = s_resp[i];
        rdata_sel = s_rdata[i*BUS_WIDTH +: BUS_WIDTH];
      end
      if (dsel == SEL_W'(i)) begin
        dfault = s_fault[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    to_flag_d = to_flag_q;
    fault     = 1'b0;
    req_d     = '0;
    in_wait   = (state_q == ST_WAIT);
    accept    = m_req & (~in_wait | resp_sel);

    if (accept) begin
      if (dec_err) begin
        fault   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        for (int unsigned i = 0; i < N_SLV; i++) begin
          req_d[i] = (dsel == SEL_W'(i));
        end
        if (dfault) begin
          fault   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sel_d   = dsel;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
    end else if (in_wait) begin
      // Not accepted while waiting implies no resp from the selected slave
      // unless m_req is low; a violating m_req only raises m_fault.
      if (resp_sel) begin
        state_d = ST_IDLE;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        fault     = 1'b1;
        to_flag_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (m_req) begin
        fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign m_rdata = rdata_sel;
  assign m_resp  = rstn & in_wait & resp_sel;
  assign m_fault = rstn & fault;
  assign s_req   = rstn ? req_d : '0;
  assign to_flag = to_flag_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Bench for periph_bus_bridge: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model with slave stubs.
module tb_periph_bus_bridge;
  import periph_bus_bridge_pkg::*;

  localparam int NS  = 4;
  localparam int TO  = 15;
  localparam int VAW = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic [31:0]      m_addr;
  logic             m_w_rb;
  logic [1:0]       m_acc;
  logic [31:0]      m_wdata;
  logic             m_req;
  logic [31:0]      m_rdata;
  logic             m_resp, m_fault;
  logic [VAW-1:0]   s_addr;
  logic             s_w_rb;
  logic [1:0]       s_acc;
  logic [31:0]      s_wdata;
  logic [NS-1:0]    s_req;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0]    s_resp;
  logic [NS-1:0]    s_fault;
  logic             to_flag;

  periph_bus_bridge #(
    .N_SLV(NS), .SEL_LSB(8), .SEL_W(4), .VA_WIDTH(VAW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc),
    .m_wdata(m_wdata), .m_req(m_req), .m_rdata(m_rdata), .m_resp(m_resp),
    .m_fault(m_fault), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
    .s_wdata(s_wdata), .s_req(s_req), .s_rdata(s_rdata), .s_resp(s_resp),
    .s_fault(s_fault), .to_flag(to_flag)
  );

  always #5 clk = ~clk;

  function automatic bit slave_faults(int idx, logic [1:0] acc);
    return (idx == int'(PBB_SLV_TMR)) && (acc == BUS_ACC_1B);
  endfunction

  always_comb begin
    s_fault = '0;
    for (int i = 0; i < NS; i++) s_fault[i] = s_req[i] & slave_faults(i, m_acc);
  end

  int checks = 0, errors = 0;
  // Model: at most one pending transaction, identified by slave and issue cycle.
  bit pend = 0;
  int pend_sel = 0, pend_issue = 0, cyc = 0;
  bit mdl_to = 0;
  // Slave stubs
  int cd[NS];
  bit hang[NS];
  bit noise_en = 0, rand_lat = 0;
  int lat = 1;
  logic [31:0] rd_drv[NS];
  logic [NS-1:0] smp_sreq;
  logic smp_resp, smp_fault, smp_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic [31:0]   a = m_addr;
    int            dsel = int'((a >> 8) & 32'hF);
    bit            err = ((a >> 12) != 0) || (((a >> VAW) & 32'h3) != 0) || (dsel >= NS);
    bit            rs = pend && s_resp[pend_sel];
    int            age = cyc - pend_issue;
    bit            acc_ok = m_req && (!pend || rs);
    bit            sf = slave_faults(dsel, m_acc);
    bit            e_resp, e_fault;
    logic [NS-1:0] e_sreq;
    logic [VAW-1:0] e_addr = a[VAW-1:0];
    e_resp  = rs;
    e_fault = (acc_ok && (err || sf)) || (m_req && pend && !rs) || (pend && !rs && age == TO);
    e_sreq  = (acc_ok && !err) ? NS'(1 << dsel) : '0;
    if (!rstn) begin
      e_resp = 0; e_fault = 0; e_sreq = '0;
    end
    smp_sreq = s_req; smp_resp = m_resp; smp_fault = m_fault; smp_to = to_flag;
    chk("m_resp", 32'(m_resp), 32'(e_resp));
    chk("m_fault", 32'(m_fault), 32'(e_fault));
    chk("s_req", 32'(s_req), 32'(e_sreq));
    chk("to_flag", 32'(to_flag), 32'(mdl_to));
    chk("s_addr", 32'(s_addr), 32'(e_addr));
    chk("s_wdata", s_wdata, m_wdata);
    chk("s_acc_w", {29'b0, s_acc, s_w_rb}, {29'b0, m_acc, m_w_rb});
    if (rstn && pend) chk("m_rdata", m_rdata, rd_drv[pend_sel]);
    if (!rstn) begin
      pend = 0; mdl_to = 0;
    end else if (acc_ok && !err && !sf) begin
      pend = 1; pend_sel = dsel; pend_issue = cyc;
    end else if (acc_ok) begin
      pend = 0;
    end else if (rs) begin
      pend = 0;
    end else if (pend && age == TO) begin
      pend = 0; mdl_to = 1;
    end
    cyc++;
  endtask

  task automatic cycle(input bit rn, input bit req, input logic [31:0] addr,
                       input bit w, input logic [1:0] acc);
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      s_resp[i] = (cd[i] == 1) || (noise_en && $urandom_range(0, 19) == 0);
      if (cd[i] > 0) cd[i]--;
      rd_drv[i] = $urandom;
      s_rdata[i*32 +: 32] = rd_drv[i];
    end
    rstn = rn; m_req = req; m_addr = addr; m_w_rb = w; m_acc = acc; m_wdata = $urandom;
    @(negedge clk);
    model_check();
    for (int i = 0; i < NS; i++)
      if (s_req[i] && !s_fault[i])
        cd[i] = hang[i] ? 0 : (rand_lat ? int'($urandom_range(1, 4)) : lat);
  endtask

  task automatic idle();
    cycle(1, 0, 32'h0, 0, BUS_ACC_4B);
  endtask

  initial begin
    rstn = 0; m_req = 0; m_addr = '0; m_w_rb = 0; m_acc = '0; m_wdata = '0;
    s_resp = '0; s_rdata = '0;
    for (int i = 0; i < NS; i++) begin cd[i] = 0; hang[i] = 0; rd_drv[i] = '0; end

    cycle(0, 0, 32'h0, 0, BUS_ACC_4B);
    cycle(0, 0, 32'h0, 0, BUS_ACC_4B);
    chk("rst_to_flag", 32'(smp_to), 32'h0);
    chk("rst_resp", 32'(smp_resp), 32'h0);
    idle();

    // Write to timer slave, then read it
    cycle(1, 1, 32'h100, 1, BUS_ACC_4B);
    chk("t1_sreq", 32'(smp_sreq), 32'h2);
    idle();
    chk("t1_resp", 32'(smp_resp), 32'h1);
    cycle(1, 1, 32'h100, 0, BUS_ACC_4B);
    idle();
    chk("t1_rd_resp", 32'(smp_resp), 32'h1);

    // Decode errors: bad select, gap bits, high bits
    cycle(1, 1, 32'h400, 0, BUS_ACC_4B);
    chk("t2_sel_fault", 32'(smp_fault), 32'h1);
    chk("t2_sel_sreq", 32'(smp_sreq), 32'h0);
    cycle(1, 1, 32'h140, 0, BUS_ACC_4B);
    chk("t2_gap_fault", 32'(smp_fault), 32'h1);
    cycle(1, 1, 32'h8000_0100, 0, BUS_ACC_4B);
    chk("t2_hi_fault", 32'(smp_fault), 32'h1);

    // Slave-reported fault on byte access
    cycle(1, 1, 32'h100, 0, BUS_ACC_1B);
    chk("t3_fault", 32'(smp_fault), 32'h1);
    idle();
    chk("t3_noresp", 32'(smp_resp), 32'h0);

    // Timeout on a silent slave, then a normal access
    hang[2] = 1;
    cycle(1, 1, 32'h200, 0, BUS_ACC_4B);
    chk("t4_sreq", 32'(smp_sreq), 32'h4);
    for (int k = 1; k <= TO; k++) begin
      idle();
      chk("t4_tofault", 32'(smp_fault), (k == TO) ? 32'h1 : 32'h0);
    end
    idle();
    chk("t4_to_flag", 32'(smp_to), 32'h1);
    hang[2] = 0;
    cycle(1, 1, 32'h104, 0, BUS_ACC_4B);
    idle();
    chk("t4_after_resp", 32'(smp_resp), 32'h1);

    // Back-to-back accesses, then a protocol violation
    cycle(1, 1, 32'h100, 0, BUS_ACC_4B);
    cycle(1, 1, 32'h104, 0, BUS_ACC_4B);
    chk("t5_b2b_resp", 32'(smp_resp), 32'h1);
    chk("t5_b2b_sreq", 32'(smp_sreq), 32'h2);
    idle();
    chk("t5_b2b_resp2", 32'(smp_resp), 32'h1);
    lat = 3;
    cycle(1, 1, 32'h100, 0, BUS_ACC_4B);
    cycle(1, 1, 32'h300, 0, BUS_ACC_4B);
    chk("t5_viol_fault", 32'(smp_fault), 32'h1);
    chk("t5_viol_sreq", 32'(smp_sreq), 32'h0);
    idle();
    idle();
    chk("t5_viol_resp", 32'(smp_resp), 32'h1);

    // Reset mid-access; late resp must be ignored
    lat = 2;
    cycle(1, 1, 32'h100, 0, BUS_ACC_4B);
    cycle(0, 0, 32'h0, 0, BUS_ACC_4B);
    chk("t6_rst_resp", 32'(smp_resp), 32'h0);
    chk("t6_rst_sreq", 32'(smp_sreq), 32'h0);
    idle();
    chk("t6_late_resp", 32'(smp_resp), 32'h0);
    chk("t6_to_flag", 32'(smp_to), 32'h0);

    // Randomized traffic
    noise_en = 1; rand_lat = 1;
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a;
      int r = int'($urandom_range(0, 9));
      a = (32'($urandom_range(0, 5)) << 8) | 32'($urandom_range(0, 63));
      if (r == 0) a = a | (32'($urandom_range(1, 3)) << VAW);
      if (r == 1) a = a | (32'h1 << (12 + $urandom_range(0, 19)));
      if ($urandom_range(0, 99) == 0) hang[2] = ~hang[2];
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 4), a,
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
